// File: rtl/sample_arb_pkg.sv
// Shared types and defaults for the audio sample FIFO write-port arbiter.
package sample_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int unsigned DEF_NUM_REQ     = 4;
    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_STALL_LIMIT = 64;
    localparam int unsigned DROP_CNT_W      = 16;
    localparam int unsigned STALL_CNT_W     = 8;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin priority encoder: first valid index at or above ptr, wrapping.
module rr_arbiter_pick
    import sample_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk candidates ptr, ptr+1, ... mod NUM_REQ and keep the first valid one.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = '0;
        cand_idx = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = 32'(ptr) + 32'(k);
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (enable && !any && req_valid[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
                any             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_write_arbiter.sv
// Round-robin arbiter feeding the sample FIFO write port through a one-deep hold register.
// Optional drop statistics (DROP_COUNT) are built when SAMPLE_ARB_STATS_EN is defined.
module sample_write_arbiter
    import sample_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = DEF_NUM_REQ,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned STALL_LIMIT = DEF_STALL_LIMIT
) (
    input  logic                        W_CLK,
    input  logic                        RESET,
    input  logic [NUM_REQ-1:0]          REQ_VALID,
    input  logic [NUM_REQ*DATA_W-1:0]   REQ_DATA,
    output logic [NUM_REQ-1:0]          REQ_READY,
    input  logic                        FIFO_FULL,
    output logic                        FIFO_WRITE,
    output logic [DATA_W-1:0]           FIFO_DIN,
    output logic [$clog2(NUM_REQ)-1:0]  GRANT_ID,
    output logic                        BUSY,
    output logic                        OVERRUN
`ifdef SAMPLE_ARB_STATS_EN
    ,
    output logic [DROP_CNT_W-1:0]       DROP_COUNT
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       grant_id_q, grant_id_d;
    logic [DATA_W-1:0]      hold_q, hold_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic                   pick_en;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_any;
    logic                   fifo_write_c;
    logic                   overrun_c;
    logic                   stall_last;

    logic [DATA_W-1:0]      req_word [NUM_REQ];

    for (genvar i = 0; i < int'(NUM_REQ); i++) begin : g_unpack
        assign req_word[i] = REQ_DATA[i*DATA_W +: DATA_W];
    end

    // The slot is free for a new grant when empty, or when the held word is written this edge.
    assign pick_en = !RESET && ((state_q == IDLE) || !FIFO_FULL);

    rr_arbiter_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_valid (REQ_VALID),
        .ptr       (ptr_q),
        .enable    (pick_en),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any       (pick_any)
    );

    assign stall_last = (stall_q == STALL_CNT_W'(STALL_LIMIT - 1));

    // Next-state, write strobe and drop decision.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_id_d   = grant_id_q;
        hold_d       = hold_q;
        stall_d      = stall_q;
        fifo_write_c = 1'b0;
        overrun_c    = 1'b0;

        if (!RESET) begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                HOLD: begin
                    if (!FIFO_FULL) begin
                        fifo_write_c = 1'b1;
                        state_d      = IDLE;
                    end else if (stall_last) begin
                        overrun_c = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        stall_d = stall_q + STALL_CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (pick_any) begin
                hold_d     = req_word[pick_idx];
                grant_id_d = pick_idx;
                ptr_d      = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                stall_d    = '0;
                state_d    = HOLD;
            end
        end
    end

    always_ff @(posedge W_CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            hold_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            hold_q     <= hold_d;
            stall_q    <= stall_d;
        end
    end

`ifdef SAMPLE_ARB_STATS_EN
    logic [DROP_CNT_W-1:0] drop_q;

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge W_CLK) begin
        if (RESET) begin
            drop_q <= '0;
        end else if (overrun_c && (drop_q != '1)) begin
            drop_q <= drop_q + DROP_CNT_W'(1);
        end
    end

    assign DROP_COUNT = drop_q;
`endif

    assign REQ_READY  = pick_grant;
    assign FIFO_WRITE = fifo_write_c;
    assign FIFO_DIN   = hold_q;
    assign GRANT_ID   = grant_id_q;
    assign BUSY       = (state_q == HOLD);
    assign OVERRUN    = overrun_c;

endmodule
